// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 8:1 mux.
// Owners keep the grant while requesting, up to MAX_HOLD cycles if others wait.
module mux8_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               preempt
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_n;

  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]   sel_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               valid_n;
  logic               preempt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [NUM_REQ-1:0] owner;
  logic [NUM_REQ-1:0] others;
  logic [SEL_W-1:0]   win_all;
  logic [SEL_W-1:0]   win_oth;
  logic [SEL_W-1:0]   win;
  logic               do_gnt;
  logic               hold_full;

  // First set bit of v, searching circularly from p+1 round to p.
  function automatic logic [SEL_W-1:0] arb(
    input logic [NUM_REQ-1:0] v,
    input logic [SEL_W-1:0]   p
  );
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    logic             hit;
    res = p;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = p + SEL_W'(i);
      if (!hit && v[idx]) begin
        res = idx;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    owner      = '0;
    owner[ptr] = 1'b1;
    others     = req & ~owner;
    win_all    = arb(req, ptr);
    win_oth    = arb(others, ptr);
    hold_full  = (MAX_HOLD != 0) &&
                 (cnt == CNT_W'(MAX_HOLD));
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    gnt_n     = gnt;
    valid_n   = valid;
    preempt_n = 1'b0;
    cnt_n     = cnt;
    win       = win_all;
    do_gnt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          do_gnt = 1'b1;
        end
      end
      BUSY: begin
        if (!req[ptr]) begin
          if (|others) begin
            do_gnt = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
            cnt_n   = '0;
          end
        end else if (hold_full && |others) begin
          // Masked search lands strictly after the owner.
          win       = win_oth;
          do_gnt    = 1'b1;
          preempt_n = 1'b1;
        end else if (cnt < CNT_W'(MAX_HOLD)) begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase

    if (do_gnt) begin
      state_n    = BUSY;
      gnt_n      = '0;
      gnt_n[win] = 1'b1;
      sel_n      = win;
      ptr_n      = win;
      valid_n    = 1'b1;
      cnt_n      = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= SEL_W'(NUM_REQ - 1);
      sel     <= '0;
      gnt     <= '0;
      valid   <= 1'b0;
      preempt <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      gnt     <= gnt_n;
      valid   <= valid_n;
      preempt <= preempt_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux datapath among 8 requesters.
- Drives the mux select and a one-hot grant vector.
- An owner keeps the grant while it holds its request, up to MAX_HOLD cycles; after that it is preempted if any other requester is waiting.
- Sits directly in front of the mux8x1 select input. The granted requester's data is the one steered to the shared output.

Parameters:
- NUM_REQ, 8, number of requesters; fixed at 8 to match the mux width.
- SEL_W, 3, select width, equal to log2(NUM_REQ).
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption; 0 disables preemption.
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector, bit i = requester i; level-sensitive.
- gnt  output 8  one-hot grant, registered; all zero when no owner.
- sel  output 3  binary index of the granted requester, registered; drives the mux select.
- valid  output 1  high while a grant is active (equals |gnt).
- preempt  output 1  one-cycle pulse in the cycle the new grant appears after a MAX_HOLD preemption.

Behaviour:
- Reset (rst high at edge): gnt=0, sel=0, valid=0, preempt=0, state=IDLE, hold_cnt=0, last-owner pointer ptr=7, so requester 0 has first priority.
- Reset overrides everything, including mid-grant. There is no partial completion.
- Arbitration function: pick the first set bit in a candidate vector, searching circularly from ptr+1 up to ptr (wrap 7->0).
- Latency: request sampled at edge N -> gnt/sel/valid updated at edge N+1. There is no combinational path from req to outputs.
- States: IDLE, BUSY.
- IDLE, req==0: stay; outputs hold (gnt=0, valid=0, sel keeps its last value).
- IDLE, req!=0: winner = arb(req). Then gnt=onehot(winner), sel=winner, valid=1, ptr=winner, hold_cnt=1, go to BUSY.
- BUSY, owner drops (req[ptr]==0), other requests present: winner = arb(req), granted next edge. No idle gap (back-to-back handover). hold_cnt=1, preempt=0.
- BUSY, owner drops, no other requests: go to IDLE. gnt=0, valid=0, sel holds the last owner.
- BUSY, owner holds, MAX_HOLD!=0, hold_cnt==MAX_HOLD, other requests present: preempt. Winner = arb(req with owner bit masked), which is strictly after the owner in circular order. hold_cnt=1, preempt=1 for one cycle.
- BUSY, owner holds, all other cases: keep the grant. hold_cnt increments and saturates at MAX_HOLD; it stays at MAX_HOLD indefinitely if nobody else requests.
- A preempted requester that keeps req high rejoins arbitration normally at its rotated priority.
- preempt is 0 in every cycle not listed above.
- Invariants: gnt is always zero or one-hot; sel==index(gnt) whenever valid=1; valid==|gnt.

Test Plan:
- Reset, then req=8'b0000_0001 at edge 1 -> edge 2: gnt=8'h01, sel=0, valid=1, preempt=0.
- From IDLE, req=8'b1000_0100 -> gnt=8'h04, sel=2. Drop bit 2 -> next edge gnt=8'h80, sel=7, valid stays 1 with no gap. Drop all -> gnt=0, valid=0, sel=7 held.
- MAX_HOLD=4, req=8'hFF held -> grant order 0,1,...,7,0. Each owner holds exactly 4 cycles. preempt pulses once per handover. sel matches gnt every cycle.
- MAX_HOLD=16, req=8'h08 held for 40 cycles -> gnt=8'h08 throughout, preempt never asserts. Raise bit 5 at cycle 40 -> gnt=8'h20 one edge later, with a preempt pulse.
- rst=1 for one edge while BUSY with owner 6 -> gnt=0, sel=0, valid=0. Then req=8'h41 -> requester 0 granted first (priority restarted).
- MAX_HOLD=0, req=8'h03 held for 100 cycles -> requester 0 keeps the grant the whole time, preempt stays 0.
